// File: rtl/bomb_countdown_ctrl.sv
// Sequencing controller for a countdown device that drives an external counter register.
// Register commands are combinational so the counter moves on the same edge as the state.
module bomb_countdown_ctrl #(
    parameter int         WIDTH      = 4,
    parameter int         INIT_VALUE = 9,
    parameter int         MAX_VALUE  = 15,
    parameter logic [3:0] CODE       = 4'hA,
    parameter int         MAX_TRIES  = 3
) (
    input  logic             clk,
    input  logic             async_nreset,
    input  logic             btn_up,
    input  logic             btn_down,
    input  logic             btn_arm,
    input  logic             btn_disarm,
    input  logic             btn_clear,
    input  logic [3:0]       disarm_code,
    input  logic             tick,
    input  logic [WIDTH-1:0] count_in,
    output logic [1:0]       ctrl,
    output logic [WIDTH-1:0] load_value,
    output logic             armed,
    output logic             exploded,
    output logic             defused,
    output logic [1:0]       tries_left
);

    // state    | meaning
    // INIT     | load counter with INIT_VALUE, refill disarm attempts
    // SETUP    | user adjusts counter with up/down, may arm
    // ARMED    | counting down on tick, accepting disarm attempts
    // EXPLODED | terminal: timer ran out or attempts exhausted
    // DEFUSED  | terminal: correct code entered, counter frozen

    typedef enum logic [2:0] {
        ST_INIT,
        ST_SETUP,
        ST_ARMED,
        ST_EXPLODED,
        ST_DEFUSED
    } state_t;

    localparam logic [1:0]       CTRL_NONE  = 2'd0;
    localparam logic [1:0]       CTRL_LOAD  = 2'd1;
    localparam logic [1:0]       CTRL_INCR  = 2'd2;
    localparam logic [1:0]       CTRL_DECR  = 2'd3;
    localparam logic [WIDTH-1:0] INIT_V     = WIDTH'(INIT_VALUE);
    localparam logic [WIDTH-1:0] MAX_V      = WIDTH'(MAX_VALUE);
    localparam logic [WIDTH-1:0] CNT_ONE    = WIDTH'(1);
    localparam logic [1:0]       TRIES_FULL = 2'(MAX_TRIES);

    state_t     state_q, state_d;
    logic [1:0] tries_q, tries_d;
    logic       code_ok;
    logic       wrong_try;
    logic       count_zero;

    assign code_ok    = btn_disarm && (disarm_code == CODE);
    assign wrong_try  = btn_disarm && (disarm_code != CODE);
    assign count_zero = (count_in == '0);

    always_ff @(posedge clk or negedge async_nreset) begin
        if (!async_nreset) begin
            state_q <= ST_INIT;
            tries_q <= TRIES_FULL;
        end else begin
            state_q <= state_d;
            tries_q <= tries_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tries_d = tries_q;
        ctrl    = CTRL_NONE;
        case (state_q)
            ST_INIT: begin
                ctrl    = CTRL_LOAD;
                tries_d = TRIES_FULL;
                state_d = ST_SETUP;
            end
            ST_SETUP: begin
                // Arming at zero is dropped so up/down still act in that cycle.
                if (btn_arm && !count_zero) begin
                    state_d = ST_ARMED;
                end else if (btn_up && !btn_down) begin
                    if (count_in < MAX_V) ctrl = CTRL_INCR;
                end else if (btn_down && !btn_up) begin
                    if (!count_zero) ctrl = CTRL_DECR;
                end
            end
            ST_ARMED: begin
                if (count_zero) begin
                    state_d = ST_EXPLODED;
                end else if (code_ok) begin
                    state_d = ST_DEFUSED;
                end else begin
                    // A wrong code and a tick in the same cycle both take effect.
                    if (tick) ctrl = CTRL_DECR;
                    if (wrong_try && tries_q != 2'd0) tries_d = tries_q - 2'd1;
                    if ((wrong_try && tries_q <= 2'd1) || (tick && count_in == CNT_ONE))
                        state_d = ST_EXPLODED;
                end
            end
            ST_EXPLODED, ST_DEFUSED: begin
                if (btn_clear) state_d = ST_INIT;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    assign load_value = INIT_V;
    assign armed      = (state_q == ST_ARMED);
    assign exploded   = (state_q == ST_EXPLODED);
    assign defused    = (state_q == ST_DEFUSED);
    assign tries_left = tries_q;

endmodule

// File: tb/tb_bomb_countdown_ctrl.sv
// Bench for bomb_countdown_ctrl: directed scenarios plus random stimulus against a
// behavioural model; the counter register the controller commands lives in the bench.
module tb_bomb_countdown_ctrl;

    localparam int         INIT_V = 9;
    localparam int         MAX_V  = 15;
    localparam int         MAX_T  = 3;
    localparam logic [3:0] CODE_V = 4'hA;

    logic       clk = 1'b0;
    logic       async_nreset;
    logic       btn_up, btn_down, btn_arm, btn_disarm, btn_clear, tick;
    logic [3:0] disarm_code;
    logic [3:0] cnt_q = 4'd0;
    logic [1:0] ctrl;
    logic [3:0] load_value;
    logic       armed, exploded, defused;
    logic [1:0] tries_left;

    always #5 clk = ~clk;

    bomb_countdown_ctrl #(
        .WIDTH(4), .INIT_VALUE(INIT_V), .MAX_VALUE(MAX_V), .CODE(CODE_V), .MAX_TRIES(MAX_T)
    ) dut (
        .clk(clk), .async_nreset(async_nreset),
        .btn_up(btn_up), .btn_down(btn_down), .btn_arm(btn_arm),
        .btn_disarm(btn_disarm), .btn_clear(btn_clear), .disarm_code(disarm_code),
        .tick(tick), .count_in(cnt_q), .ctrl(ctrl), .load_value(load_value),
        .armed(armed), .exploded(exploded), .defused(defused), .tries_left(tries_left)
    );

    // Counter register obeying the controller's command.
    always @(posedge clk) begin
        case (ctrl)
            2'd1: cnt_q <= load_value;
            2'd2: cnt_q <= cnt_q + 4'd1;
            2'd3: cnt_q <= cnt_q - 4'd1;
            default: ;
        endcase
    end

    typedef enum int {M_INIT, M_SETUP, M_ARMED, M_EXPL, M_DEF} mstate_t;
    mstate_t m_state;
    int      m_tries;
    int      m_count;
    int      n_checks = 0;
    int      n_errors = 0;
    int      last_ctrl;

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int flags_of(input mstate_t s);
        return (s == M_ARMED) ? 4 : (s == M_EXPL) ? 2 : (s == M_DEF) ? 1 : 0;
    endfunction

    task automatic cycle(input bit up, input bit dn, input bit arm, input bit dis,
                         input logic [3:0] code, input bit tk, input bit clr);
        int      e_ctrl;
        int      e_tries;
        mstate_t e_state;
        bool_ok: begin end
        @(negedge clk);
        btn_up = up; btn_down = dn; btn_arm = arm; btn_disarm = dis;
        disarm_code = code; tick = tk; btn_clear = clr;
        #1;
        e_ctrl  = 0;
        e_tries = m_tries;
        e_state = m_state;
        case (m_state)
            M_INIT: begin
                e_ctrl = 1; e_tries = MAX_T; e_state = M_SETUP;
            end
            M_SETUP: begin
                if (arm && m_count != 0) e_state = M_ARMED;
                else if (up && !dn && m_count < MAX_V) e_ctrl = 2;
                else if (dn && !up && m_count > 0) e_ctrl = 3;
            end
            M_ARMED: begin
                if (m_count == 0) e_state = M_EXPL;
                else if (dis && code == CODE_V) e_state = M_DEF;
                else begin
                    if (tk) e_ctrl = 3;
                    if (dis) begin
                        if (m_tries > 0) e_tries = m_tries - 1;
                        if (m_tries <= 1) e_state = M_EXPL;
                    end
                    if (tk && m_count == 1) e_state = M_EXPL;
                end
            end
            default: if (clr) e_state = M_INIT;
        endcase
        last_ctrl = int'(ctrl);
        check_val("ctrl", int'(ctrl), e_ctrl);
        check_val("load_value", int'(load_value), INIT_V);
        check_val("tries_left", int'(tries_left), m_tries);
        check_val("flags", int'({armed, exploded, defused}), flags_of(m_state));
        @(posedge clk);
        #1;
        m_state = e_state;
        m_tries = e_tries;
        if (e_ctrl == 1) m_count = INIT_V;
        else if (e_ctrl == 2) m_count = m_count + 1;
        else if (e_ctrl == 3) m_count = m_count - 1;
        check_val("count", int'(cnt_q), m_count);
        check_val("flags_post", int'({armed, exploded, defused}), flags_of(m_state));
        btn_up = 0; btn_down = 0; btn_arm = 0; btn_disarm = 0; tick = 0; btn_clear = 0;
    endtask

    task automatic idle();
        cycle(0, 0, 0, 0, 4'h0, 0, 0);
    endtask

    // Called just after a posedge; the whole pulse sits between clock edges.
    task automatic reset_pulse();
        #1 async_nreset = 1'b0;
        #1;
        m_state = M_INIT;
        m_tries = MAX_T;
        check_val("rst_flags", int'({armed, exploded, defused}), 0);
        check_val("rst_ctrl", int'(ctrl), 1);
        check_val("rst_tries", int'(tries_left), MAX_T);
        check_val("rst_load", int'(load_value), INIT_V);
        #1 async_nreset = 1'b1;
    endtask

    bit         r_up, r_dn, r_arm, r_dis, r_tk, r_clr;
    logic [3:0] r_code;

    initial begin
        btn_up = 0; btn_down = 0; btn_arm = 0; btn_disarm = 0; btn_clear = 0;
        tick = 0; disarm_code = 4'h0;
        async_nreset = 1'b1;
        #2 async_nreset = 1'b0;
        #1;
        check_val("rst0_flags", int'({armed, exploded, defused}), 0);
        check_val("rst0_ctrl", int'(ctrl), 1);
        check_val("rst0_tries", int'(tries_left), MAX_T);
        #25 async_nreset = 1'b1;
        // Edges during reset saw ctrl=LOAD, so the register already holds INIT_V.
        m_state = M_INIT;
        m_tries = MAX_T;
        m_count = INIT_V;

        idle();
        check_val("r41_count", int'(cnt_q), 9);
        check_val("r41_tries", int'(tries_left), 3);

        for (int i = 0; i < 6; i++) cycle(1, 0, 0, 0, 4'h0, 0, 0);
        check_val("r42_sat6", int'(cnt_q), 15);
        for (int i = 0; i < 2; i++) cycle(1, 0, 0, 0, 4'h0, 0, 0);
        check_val("r42_sat8", int'(cnt_q), 15);
        cycle(1, 1, 0, 0, 4'h0, 0, 0);
        check_val("r42_both", last_ctrl, 0);

        for (int i = 0; i < 13; i++) cycle(0, 1, 0, 0, 4'h0, 0, 0);
        check_val("r43_cnt2", int'(cnt_q), 2);
        cycle(0, 0, 1, 0, 4'h0, 0, 0);
        check_val("r43_armed", int'(armed), 1);
        cycle(0, 0, 0, 0, 4'h0, 1, 0);
        check_val("r43_tick1", last_ctrl, 3);
        cycle(0, 0, 0, 0, 4'h0, 1, 0);
        check_val("r43_expl", int'(exploded), 1);
        check_val("r43_cnt0", int'(cnt_q), 0);
        cycle(1, 0, 1, 1, 4'hA, 1, 0);
        check_val("r43_frozen", last_ctrl, 0);
        cycle(0, 0, 0, 0, 4'h0, 0, 1);
        idle();
        check_val("r43_reload", int'(cnt_q), 9);

        for (int i = 0; i < 4; i++) cycle(0, 1, 0, 0, 4'h0, 0, 0);
        cycle(0, 0, 1, 0, 4'h0, 0, 0);
        cycle(0, 0, 0, 1, 4'h3, 0, 0);
        check_val("r44_tries2", int'(tries_left), 2);
        cycle(0, 0, 0, 1, 4'h7, 0, 0);
        check_val("r44_tries1", int'(tries_left), 1);
        cycle(0, 0, 0, 1, 4'hA, 1, 0);
        check_val("r44_defused", int'(defused), 1);
        check_val("r44_cnt5", int'(cnt_q), 5);
        cycle(0, 0, 0, 0, 4'h0, 0, 1);
        idle();

        cycle(0, 0, 1, 0, 4'h0, 0, 0);
        cycle(0, 0, 0, 1, 4'h3, 0, 0);
        cycle(0, 0, 0, 1, 4'h7, 0, 0);
        for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0, 4'h0, 1, 0);
        check_val("r45_cnt4", int'(cnt_q), 4);
        cycle(0, 0, 0, 1, 4'h5, 1, 0);
        check_val("r45_expl", int'(exploded), 1);
        check_val("r45_cnt3", int'(cnt_q), 3);
        check_val("r45_tries0", int'(tries_left), 0);
        cycle(0, 0, 0, 0, 4'h0, 0, 1);
        check_val("r45_init", int'({armed, exploded, defused}), 0);
        idle();
        check_val("r45_reload", int'(cnt_q), 9);

        cycle(0, 0, 1, 0, 4'h0, 0, 0);
        cycle(0, 0, 0, 0, 4'h0, 1, 0);
        cycle(0, 0, 0, 0, 4'h0, 1, 0);
        check_val("r46_cnt7", int'(cnt_q), 7);
        reset_pulse();
        idle();
        check_val("r46_reload", int'(cnt_q), 9);

        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 249) == 0) begin
                reset_pulse();
            end else begin
                r_up   = ($urandom_range(0, 2) == 0);
                r_dn   = ($urandom_range(0, 2) == 0);
                r_arm  = ($urandom_range(0, 7) == 0);
                r_dis  = ($urandom_range(0, 5) == 0);
                r_tk   = ($urandom_range(0, 2) == 0);
                r_clr  = ($urandom_range(0, 9) == 0);
                r_code = ($urandom_range(0, 2) == 0) ? CODE_V : 4'($urandom);
                cycle(r_up, r_dn, r_arm, r_dis, r_code, r_tk, r_clr);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bomb_countdown_ctrl.md
BOMB_COUNTDOWN_CTRL -- requirements
Module: bomb_countdown_ctrl

Interface
REQ-001 Parameter WIDTH, default 4: width of the counter value exchanged with the counter register.
REQ-002 Parameter INIT_VALUE, default 9: value loaded into the counter on entry to INIT.
REQ-003 Parameter MAX_VALUE, default 15: upper bound for setup increments.
REQ-004 Parameter CODE, default 4'hA: 4-bit disarm code.
REQ-005 Parameter MAX_TRIES, default 3: number of wrong codes that causes detonation, range 1..3.
REQ-006 Port clk, input, 1: single clock; all state changes occur on its rising edge.
REQ-007 Port async_nreset, input, 1: asynchronous, active-low reset.
REQ-008 Port btn_up, input, 1: single-cycle increment request.
REQ-009 Port btn_down, input, 1: single-cycle decrement request.
REQ-010 Port btn_arm, input, 1: single-cycle arm request.
REQ-011 Port btn_disarm, input, 1: single-cycle disarm attempt, qualified by disarm_code.
REQ-012 Port btn_clear, input, 1: single-cycle return to INIT from a terminal state.
REQ-013 Port disarm_code, input, 4: code sampled when btn_disarm=1.
REQ-014 Port tick, input, 1: single-cycle timebase pulse (1 s).
REQ-015 Port count_in, input, WIDTH: current counter register value.
REQ-016 Port ctrl, output, 2: register command; NONE=0, LOAD=1, INCR=2, DECR=3.
REQ-017 Port load_value, output, WIDTH: data presented with LOAD.
REQ-018 Ports armed, exploded, defused, outputs, 1 each: state flags.
REQ-019 Port tries_left, output, 2: remaining disarm attempts.

Function
REQ-020 States SHALL be INIT, SETUP, ARMED, EXPLODED, DEFUSED, held in a registered state variable.
REQ-021 ctrl and load_value SHALL be combinational from the current state and inputs, so the counter register updates on the same edge as the state transition.
REQ-022 load_value SHALL equal INIT_VALUE at all times.
REQ-023 INIT: ctrl=LOAD; tries_left is set to MAX_TRIES; next state SETUP unconditionally after 1 cycle.
REQ-024 SETUP, btn_arm=1, count_in!=0: ctrl=NONE; next state ARMED; btn_up and btn_down are ignored that cycle.
REQ-025 SETUP, btn_arm=1, count_in==0: the arm request is ignored; up/down are evaluated normally.
REQ-026 SETUP, btn_up=1, btn_down=0, count_in<MAX_VALUE: ctrl=INCR; at MAX_VALUE: ctrl=NONE (saturate, no wrap).
REQ-027 SETUP, btn_down=1, btn_up=0, count_in>0: ctrl=DECR; at 0: ctrl=NONE.
REQ-028 SETUP, btn_up=1 and btn_down=1: ctrl=NONE.
REQ-029 ARMED, btn_disarm=1, disarm_code==CODE: ctrl=NONE (counter frozen); next state DEFUSED; a simultaneous tick is ignored.
REQ-030 ARMED, btn_disarm=1, wrong code: tries_left is decremented; if tries_left was 1, next state is EXPLODED with ctrl=NONE.
REQ-031 ARMED, tick=1, no correct disarm: ctrl=DECR; if count_in==1, next state EXPLODED (counter reaches 0 on the same edge).
REQ-032 ARMED, wrong code and tick in the same cycle: both REQ-030 and REQ-031 effects apply; EXPLODED if either condition fires.
REQ-033 ARMED, count_in==0 on entry: next state EXPLODED.
REQ-034 EXPLODED/DEFUSED: ctrl=NONE; all buttons except btn_clear are ignored; btn_clear moves to INIT.
REQ-035 btn_clear SHALL have no effect in INIT, SETUP or ARMED.
REQ-036 armed, exploded and defused SHALL be 1 exactly when the state is ARMED, EXPLODED or DEFUSED respectively.
REQ-037 tries_left SHALL never underflow below 0.

Reset
REQ-038 While async_nreset=0, the state SHALL be INIT, tries_left=MAX_TRIES, armed=exploded=defused=0, ctrl=LOAD, load_value=INIT_VALUE.
REQ-039 Reset assertion in any state, including mid-countdown, SHALL force INIT immediately without waiting for clk.
REQ-040 After release, the first edge SHALL perform the INIT LOAD, and the second edge SHALL be the first edge in SETUP.

Verification
REQ-041 Reset release, model register: count=9 after 1 clk, state SETUP, tries_left=3.
REQ-042 SETUP count=9, btn_up x8 -> count 15 after 6 pulses, then stays 15; btn_up+btn_down together -> ctrl=NONE.
REQ-043 Arm at count=2, 2 ticks -> DECR each; exploded=1 on the 2nd tick edge, count=0; further ticks -> ctrl=NONE.
REQ-044 Armed count=5: codes 3, 7, then btn_disarm with code A in the same cycle as a tick -> tries_left 3->2->1, then defused=1, count stays 5.
REQ-045 Armed, tries_left=1, wrong code together with tick at count=4 -> exploded=1, count=3; btn_clear -> INIT, then count=9.
REQ-046 async_nreset pulsed low mid-countdown between clock edges -> flags clear immediately, ctrl=LOAD, next edge count=9.
